// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared display codes, FSM state type and helpers for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

  // Seven-seg codes that sit outside the 0..9 digit range.
  localparam logic [3:0] SEG_OFF   = 4'hF;
  localparam logic [3:0] SEG_MINUS = 4'hA;

  typedef enum logic [1:0] {
    B2B_IDLE   = 2'd0,
    B2B_SHIFT  = 2'd1,
    B2B_FINISH = 2'd2
  } b2b_state_e;

  // Code shown in place of a leading zero digit.
  function automatic logic [3:0] lz_code(input bit blank);
    return blank ? SEG_OFF : 4'd0;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble correction cell: nibbles of 5 or more get +3 before the next left shift.
module bcd_add3 (
  input  logic [3:0] in_nib,
  output logic [3:0] out_nib
);

  assign out_nib = (in_nib >= 4'd5) ? (in_nib + 4'd3) : in_nib;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Signed binary to 3-digit BCD + sign, one bit per clock, with start/busy/done handshake.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic [3:0]       out_ones,
  output logic [3:0]       out_tens,
  output logic [3:0]       out_huns,
  output logic [3:0]       sign,
  output logic             neg,
  output logic             ovf
);

  localparam int               CW  = $clog2(WIDTH + 1);
  localparam logic [3:0]       LZ  = lz_code(BLANK_LZ);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  b2b_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [15:0]      bcd_q, bcd_d;
  logic             neg_r_q, neg_r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [3:0]       ones_q, ones_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       huns_q, huns_d;
  logic [3:0]       sign_q, sign_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;

  logic [15:0]      bcd_adj;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_add3
      bcd_add3 u_add3 (
        .in_nib (bcd_q[gi*4 +: 4]),
        .out_nib(bcd_adj[gi*4 +: 4])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    neg_r_d = neg_r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ones_d  = ones_q;
    tens_d  = tens_q;
    huns_d  = huns_q;
    sign_d  = sign_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;

    case (state_q)
      B2B_IDLE: begin
        if (start) begin
          neg_r_d = bin_in[WIDTH-1];
          // Two's-complement negate as unsigned, so the most negative value maps to its magnitude.
          mag_d   = bin_in[WIDTH-1] ? (~bin_in + ONE) : bin_in;
          bcd_d   = 16'd0;
          cnt_d   = CW'(WIDTH);
          busy_d  = 1'b1;
          state_d = B2B_SHIFT;
        end
      end

      B2B_SHIFT: begin
        bcd_d = {bcd_adj[14:0], mag_q[WIDTH-1]};
        mag_d = {mag_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = B2B_FINISH;
        end
      end

      B2B_FINISH: begin
        state_d = B2B_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        // A zero magnitude never reports as negative.
        neg_d   = neg_r_q && (bcd_q != 16'd0);
        sign_d  = neg_d ? SEG_MINUS : SEG_OFF;
        if (bcd_q[15:12] != 4'd0) begin
          ovf_d  = 1'b1;
          ones_d = 4'd9;
          tens_d = 4'd9;
          huns_d = 4'd9;
        end else begin
          ovf_d  = 1'b0;
          ones_d = bcd_q[3:0];
          huns_d = (bcd_q[11:8] == 4'd0) ? LZ : bcd_q[11:8];
          tens_d = (bcd_q[11:4] == 8'd0) ? LZ : bcd_q[7:4];
        end
      end

      default: begin
        state_d = B2B_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= B2B_IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      bcd_q   <= '0;
      neg_r_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ones_q  <= 4'd0;
      tens_q  <= LZ;
      huns_q  <= LZ;
      sign_q  <= SEG_OFF;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      neg_r_q <= neg_r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      huns_q  <= huns_d;
      sign_q  <= sign_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign out_ones = ones_q;
  assign out_tens = tens_q;
  assign out_huns = huns_q;
  assign sign     = sign_q;
  assign neg      = neg_q;
  assign ovf      = ovf_q;

endmodule
